// File: rtl/fadd_accum.sv
// Streaming binary32 accumulator wrapped around an external combinational adder (fadd).
// Optional macro FADD_ACCUM_PIPE_EN registers the element operand, giving one element per two cycles.
module fadd_accum #(
    parameter int LEN_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [LEN_W-1:0] len,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_data,
    output logic [31:0]      add_a,
    output logic [31:0]      add_b,
    input  logic [31:0]      add_sum,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_data,
    output logic             busy
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ACCUM = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;
    localparam logic [1:0] ST_WAIT  = 2'd3;

    localparam logic [LEN_W-1:0] CNT_ZERO = {LEN_W{1'b0}};
    localparam logic [LEN_W-1:0] CNT_ONE  = {{(LEN_W-1){1'b0}}, 1'b1};

    logic [1:0]       r_state;
    logic [31:0]      r_acc;
    logic [LEN_W-1:0] r_cnt;
    logic             r_in_ready;
    logic             r_out_valid;
    logic             r_busy;

    logic [1:0]       w_state_nxt;
    logic [31:0]      w_acc_nxt;
    logic [LEN_W-1:0] w_cnt_nxt;
    logic             w_xfer;

    // r_in_ready always mirrors state==ACCUM, so it doubles as the transfer qualifier
    assign w_xfer = in_valid & r_in_ready;

`ifdef FADD_ACCUM_PIPE_EN
    logic [31:0] r_opb;
    logic [31:0] w_opb_nxt;
`endif

    // Next-state and datapath update selection
    always_comb begin
        w_state_nxt = r_state;
        w_acc_nxt   = r_acc;
        w_cnt_nxt   = r_cnt;
`ifdef FADD_ACCUM_PIPE_EN
        w_opb_nxt   = r_opb;
`endif
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_acc_nxt = 32'h0000_0000;
                    if (len != CNT_ZERO) begin
                        w_cnt_nxt   = len;
                        w_state_nxt = ST_ACCUM;
                    end else begin
                        w_state_nxt = ST_DONE;
                    end
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_ACCUM: begin
                if (w_xfer) begin
                    w_cnt_nxt = r_cnt - CNT_ONE;
`ifdef FADD_ACCUM_PIPE_EN
                    w_opb_nxt   = in_data;
                    w_state_nxt = ST_WAIT;
`else
                    w_acc_nxt = add_sum;
                    if (r_cnt == CNT_ONE) begin
                        w_state_nxt = ST_DONE;
                    end else begin
                        w_state_nxt = ST_ACCUM;
                    end
`endif
                end else begin
                    w_state_nxt = ST_ACCUM;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_state_nxt = ST_DONE;
                end
            end
`ifdef FADD_ACCUM_PIPE_EN
            ST_WAIT: begin
                w_acc_nxt = add_sum;
                if (r_cnt == CNT_ZERO) begin
                    w_state_nxt = ST_DONE;
                end else begin
                    w_state_nxt = ST_ACCUM;
                end
            end
`endif
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // State, running sum and remaining-element counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_acc   <= 32'h0000_0000;
            r_cnt   <= CNT_ZERO;
        end else begin
            r_state <= w_state_nxt;
            r_acc   <= w_acc_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Handshake outputs registered from the next state so they are glitch-free
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_in_ready  <= 1'b0;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_in_ready  <= (w_state_nxt == ST_ACCUM);
            r_out_valid <= (w_state_nxt == ST_DONE);
            r_busy      <= (w_state_nxt != ST_IDLE);
        end
    end

`ifdef FADD_ACCUM_PIPE_EN
    // Element operand register cutting the in_data -> adder -> acc path
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_opb <= 32'h0000_0000;
        end else begin
            r_opb <= w_opb_nxt;
        end
    end

    assign add_b = r_opb;
`else
    assign add_b = in_data;
`endif

    assign add_a     = r_acc;
    assign out_data  = r_acc;
    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign busy      = r_busy;

endmodule

// File: tb/tb_fadd_accum.sv
// Randomized self-checking bench for fadd_accum; supplies a behavioural binary32 adder
// and compares against an exact integer (half-unit) model of the running sum.
module tb_fadd_accum;

    localparam int LEN_W = 8;
`ifdef FADD_ACCUM_PIPE_EN
    localparam int XLAT = 2;
`else
    localparam int XLAT = 1;
`endif

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [LEN_W-1:0] len;
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      in_data;
    logic [31:0]      add_a;
    logic [31:0]      add_b;
    logic [31:0]      add_sum;
    logic             out_valid;
    logic             out_ready;
    logic [31:0]      out_data;
    logic             busy;

    int          n_err = 0;
    int          n_chk = 0;
    logic [31:0] elems [0:255];

    always #5 clk = ~clk;

    // binary32 -> real for normal numbers and zero (stimulus never holds inf/NaN)
    function automatic real f2r(input logic [31:0] b);
        real v;
        int  e;
        if (b[30:0] == 31'd0) return 0.0;
        e = int'(b[30:23]);
        if (e == 0) v = (real'(b[22:0]) / 8388608.0) * (2.0 ** (-126));
        else        v = (1.0 + real'(b[22:0]) / 8388608.0) * (2.0 ** (e - 127));
        return b[31] ? -v : v;
    endfunction

    // real -> binary32 with round-to-nearest on the mantissa; values here are exactly representable
    function automatic logic [31:0] r2f(input real v);
        real         a;
        int          e;
        int          m;
        int          guard;
        logic [31:0] res;
        if (v == 0.0) return 32'h0000_0000;
        a = (v < 0.0) ? -v : v;
        e = 127;
        guard = 0;
        while (a >= 2.0 && guard < 300) begin a = a / 2.0; e++; guard++; end
        while (a < 1.0 && guard < 300) begin a = a * 2.0; e--; guard++; end
        m = $rtoi((a - 1.0) * 8388608.0 + 0.5);
        res = {(v < 0.0), 8'(e), 23'(m)};
        return res;
    endfunction

    function automatic logic [31:0] f_add(input logic [31:0] a, input logic [31:0] b);
        return r2f(f2r(a) + f2r(b));
    endfunction

    assign add_sum = f_add(add_a, add_b);

    fadd_accum #(.LEN_W(LEN_W)) dut (
        .clk(clk), .rst(rst), .start(start), .len(len),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .add_a(add_a), .add_b(add_b), .add_sum(add_sum),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .busy(busy)
    );

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_chk++;
        if (obs !== exp_v) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp_v);
        end
    endtask

    function automatic logic [31:0] rand_small();
        return r2f(real'(int'($urandom_range(0, 32)) - 16) / 2.0);
    endfunction

    // gap: 0 back-to-back, 1 alternate cycles, 2 random; stall: cycles out_ready held low
    task automatic run_job(input int n, input int gap, input int stall,
                           input logic [31:0] exp_sum, input string tag);
        int   idx;
        int   cyc;
        int   last;
        logic exp_rdy;
        @(negedge clk);
        start = 1'b1; len = LEN_W'(n); in_valid = 1'b0; out_ready = (stall == 0);
        @(negedge clk);
        start = 1'b0; len = LEN_W'($urandom);
        cyc = 1; idx = 0; last = -10;
        check_val({tag, "_busy"}, 32'(busy), 32'd1);
        while (!out_valid && cyc < 300) begin
            exp_rdy = (idx < n) && (XLAT == 1 || last != cyc - 1);
            check_val({tag, "_rdy"}, 32'(in_ready), 32'(exp_rdy));
            in_valid = (idx < n) && (gap == 0 || (gap == 1 && cyc % 2 == 1) ||
                                     (gap == 2 && $urandom_range(0, 1) == 1));
            in_data  = in_valid ? elems[idx] : rand_small();
            if (in_valid && in_ready) begin
                idx++;
                last = cyc;
            end
            @(negedge clk);
            cyc++;
        end
        in_valid = 1'b0;
        check_val({tag, "_done"}, 32'(out_valid), 32'd1);
        check_val({tag, "_lat"}, 32'(cyc), 32'((n == 0) ? 1 : last + XLAT));
        check_val({tag, "_sum"}, out_data, exp_sum);
        check_val({tag, "_rdy_done"}, 32'(in_ready), 32'd0);
        for (int s = 0; s < stall; s++) begin
            start = 1'b1;
            len   = LEN_W'($urandom_range(1, 9));
            @(negedge clk);
            check_val({tag, "_stall_v"}, 32'(out_valid), 32'd1);
            check_val({tag, "_stall_d"}, out_data, exp_sum);
            check_val({tag, "_stall_b"}, 32'(busy), 32'd1);
        end
        out_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check_val({tag, "_drop_v"}, 32'(out_valid), 32'd0);
        check_val({tag, "_drop_b"}, 32'(busy), 32'd0);
    endtask

    initial begin
        int          n;
        int          k;
        int          sum_h;
        int          idx;
        int          guard;
        rst = 1'b1; start = 1'b0; len = '0; in_valid = 1'b0; in_data = 32'h0; out_ready = 1'b0;
        repeat (3) @(negedge clk);
        check_val("rst_rdy", 32'(in_ready), 32'd0);
        check_val("rst_ov", 32'(out_valid), 32'd0);
        check_val("rst_busy", 32'(busy), 32'd0);
        check_val("rst_data", out_data, 32'h0);
        rst = 1'b0;

        elems[0] = 32'h3F80_0000; elems[1] = 32'h4000_0000; elems[2] = 32'h4040_0000;
        run_job(3, 0, 0, 32'h40C0_0000, "s1");

        elems[0] = 32'h4040_0000; elems[1] = 32'hBF80_0000;
        run_job(2, 1, 0, 32'h4000_0000, "s2");

        run_job(0, 0, 0, 32'h0000_0000, "s3");

        elems[0] = 32'h3F00_0000;
        run_job(1, 0, 5, 32'h3F00_0000, "s4");

        // Mid-job reset after two transfers
        for (int i = 0; i < 4; i++) elems[i] = r2f(real'(i + 2));
        @(negedge clk);
        start = 1'b1; len = LEN_W'(4);
        @(negedge clk);
        start = 1'b0; idx = 0; guard = 0;
        while (idx < 2 && guard < 20) begin
            in_valid = 1'b1; in_data = elems[idx];
            if (in_ready) idx++;
            @(negedge clk);
            guard++;
        end
        in_valid = 1'b0;
        check_val("s5_xfers", 32'(idx), 32'd2);
        rst = 1'b1;
        #1;
        check_val("s5_rdy", 32'(in_ready), 32'd0);
        check_val("s5_ov", 32'(out_valid), 32'd0);
        check_val("s5_busy", 32'(busy), 32'd0);
        check_val("s5_data", out_data, 32'h0);
        check_val("s5_adda", add_a, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        elems[0] = 32'h3F80_0000;
        run_job(1, 0, 0, 32'h3F80_0000, "s5_new");

        // Random jobs: elements are multiples of 0.5, so every partial sum is exact
        for (int j = 0; j < 10; j++) begin
            n = int'($urandom_range(1, 12));
            sum_h = 0;
            for (int i = 0; i < n; i++) begin
                k = int'($urandom_range(0, 32)) - 16;
                sum_h += k;
                elems[i] = r2f(real'(k) / 2.0);
            end
            run_job(n, int'($urandom_range(0, 2)), int'($urandom_range(0, 3)),
                    r2f(real'(sum_h) / 2.0), $sformatf("rnd%0d", j));
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
